// File: rtl/minimal_seq_ctrl.sv
// ---------------------------------------------------------------------------
// minimal_seq_ctrl
//
// Sequencer for a single-bit datapath. It drives the datapath input through
// a programmable waveform (low_len cycles of 0, then high_len cycles of 1)
// for a programmed number of repetitions. On the last cycle of each high
// phase it samples the datapath output and counts the highs it sees.
//
// Build option:
//   MINSEQ_ABORT_EN - when defined, adds the 'abort' input, which ends a run
//                     from LOW or HIGH straight back to IDLE without 'done'.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, sampled only in IDLE
//   abort     in   (MINSEQ_ABORT_EN only) cancel the run in LOW/HIGH
//   low_len   in   CNT_W  cycles of drv_i=0 per repetition (0 acts as 1)
//   high_len  in   CNT_W  cycles of drv_i=1 per repetition (0 acts as 1)
//   reps      in   REP_W  number of repetitions (0 -> immediate done)
//   dp_o      in   datapath output, sampled on the last HIGH cycle
//   drv_i     out  drives the datapath input
//   busy      out  high in LOW and HIGH
//   done      out  one-cycle pulse at normal completion
//   hit_cnt   out  REP_W+1  number of sampled highs in the current/last run
// ---------------------------------------------------------------------------
module minimal_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef MINSEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] high_len,
    input  logic [REP_W-1:0] reps,
    input  logic             dp_o,
    output logic             drv_i,
    output logic             busy,
    output logic             done,
    output logic [REP_W:0]   hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] phase_q,    phase_d;
    logic [REP_W-1:0] rep_q,      rep_d;
    logic [CNT_W-1:0] low_len_q,  low_len_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [REP_W-1:0] reps_q,     reps_d;
    logic [REP_W:0]   hit_q,      hit_d;
    logic             drv_q,      drv_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             abort_req;
    logic [CNT_W-1:0] low_eff;
    logic [CNT_W-1:0] high_eff;
    logic             low_last;
    logic             high_last;
    logic [REP_W-1:0] rep_next;

`ifdef MINSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // A programmed length of zero still produces one cycle of that phase.
    assign low_eff   = (low_len_q  == '0) ? CNT_W'(1) : low_len_q;
    assign high_eff  = (high_len_q == '0) ? CNT_W'(1) : high_len_q;
    assign low_last  = (phase_q == low_eff  - CNT_W'(1));
    assign high_last = (phase_q == high_eff - CNT_W'(1));
    // rep_q is always below reps_q while running, so this cannot wrap.
    assign rep_next  = rep_q + REP_W'(1);

    // ---------------------------------------------------------------------
    // State register (also holds counters, latched settings and outputs)
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            rep_q      <= '0;
            low_len_q  <= '0;
            high_len_q <= '0;
            reps_q     <= '0;
            hit_q      <= '0;
            drv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rep_q      <= rep_d;
            low_len_q  <= low_len_d;
            high_len_q <= high_len_d;
            reps_q     <= reps_d;
            hit_q      <= hit_d;
            drv_q      <= drv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: hold-value defaults up front guarantee every path assigns
        // every signal, so no latches are inferred.
        state_d    = state_q;
        phase_d    = phase_q;
        rep_d      = rep_q;
        low_len_d  = low_len_q;
        high_len_d = high_len_q;
        reps_d     = reps_q;
        hit_d      = hit_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    low_len_d  = low_len;
                    high_len_d = high_len;
                    reps_d     = reps;
                    hit_d      = '0;
                    phase_d    = '0;
                    rep_d      = '0;
                    state_d    = (reps == '0) ? S_DONE : S_LOW;
                end
            end

            S_LOW: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    rep_d   = '0;
                end else if (low_last) begin
                    state_d = S_HIGH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end

            S_HIGH: begin
                // Abort wins over the phase end, so a sample due now is dropped.
                if (abort_req) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    rep_d   = '0;
                end else if (high_last) begin
                    if (dp_o) begin
                        hit_d = hit_q + (REP_W+1)'(1);
                    end
                    phase_d = '0;
                    rep_d   = rep_next;
                    state_d = (rep_next == reps_q) ? S_DONE : S_LOW;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                rep_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: decoded from the next state and registered, so outputs
    // change on the same edge the state does.
    // ---------------------------------------------------------------------
    always_comb begin
        drv_d  = (state_d == S_HIGH);
        busy_d = (state_d == S_LOW) || (state_d == S_HIGH);
        done_d = (state_d == S_DONE);
    end

    assign drv_i   = drv_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_minimal_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for minimal_seq_ctrl.
// The stimulus side computes each run's expected waveform and hit count from
// the sequencing rules and queues them; an independent monitor compares the
// DUT outputs against those queues whenever the DUT is busy or pulses done.
// ---------------------------------------------------------------------------
module tb_minimal_seq_ctrl;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [CNT_W-1:0] low_len  = '0;
    logic [CNT_W-1:0] high_len = '0;
    logic [REP_W-1:0] reps     = '0;
    logic             dp_o     = 1'b0;
`ifdef MINSEQ_ABORT_EN
    logic             abort    = 1'b0;
`endif
    logic             drv_i;
    logic             busy;
    logic             done;
    logic [REP_W:0]   hit_cnt;

    minimal_seq_ctrl #(
        .CNT_W(CNT_W),
        .REP_W(REP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef MINSEQ_ABORT_EN
        .abort    (abort),
`endif
        .low_len  (low_len),
        .high_len (high_len),
        .reps     (reps),
        .dp_o     (dp_o),
        .drv_i    (drv_i),
        .busy     (busy),
        .done     (done),
        .hit_cnt  (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy_len;
        int hits;
    } run_exp_t;

    run_exp_t exp_q[$];
    bit       drv_exp_q[$];

    int total    = 0;
    int bad      = 0;
    int busy_run = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
                check("drv_expected_present", int'(drv_exp_q.size() != 0), 1);
                if (drv_exp_q.size() != 0) begin
                    bit e;
                    e = drv_exp_q.pop_front();
                    check("drv_busy", int'(drv_i), int'(e));
                end
            end else begin
                check("drv_not_busy", int'(drv_i), 0);
            end

            if (done) begin
                check("done_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    run_exp_t e;
                    e = exp_q.pop_front();
                    check("busy_len", busy_run, e.busy_len);
                    check("hit_cnt_at_done", int'(hit_cnt), e.hits);
                end
                busy_run = 0;
            end else if (!busy) begin
                busy_run = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // One complete run. The expected waveform is built repetition by
    // repetition: max(L,1) zeros then max(H,1) ones; the datapath value on the
    // last one of each repetition is what gets counted.
    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    // -----------------------------------------------------------------------
    task automatic run(input int r, input int l, input int h,
                       input bit all_ones, input bit change_mid);
        int le;
        int he;
        int hits;
        bit dp_sched[$];
        le   = (l == 0) ? 1 : l;
        he   = (h == 0) ? 1 : h;
        hits = 0;
        for (int k = 0; k < r; k++) begin
            for (int j = 0; j < le; j++) begin
                drv_exp_q.push_back(1'b0);
                dp_sched.push_back(bit'($urandom_range(0, 1)));
            end
            for (int j = 0; j < he; j++) begin
                bit d;
                d = all_ones ? 1'b1 : bit'($urandom_range(0, 1));
                drv_exp_q.push_back(1'b1);
                dp_sched.push_back(d);
                if (j == he - 1 && d) hits++;
            end
        end
        exp_q.push_back('{busy_len: r * (le + he), hits: hits});

        start    = 1'b1;
        low_len  = CNT_W'(l);
        high_len = CNT_W'(h);
        reps     = REP_W'(r);
        @(posedge clk); #1;
        start = 1'b0;
        if (change_mid) begin
            low_len  = CNT_W'($urandom_range(0, 9));
            high_len = CNT_W'($urandom_range(0, 9));
            reps     = REP_W'($urandom_range(0, 15));
        end
        foreach (dp_sched[t]) begin
            dp_o = dp_sched[t];
            @(posedge clk); #1;
        end
        // Now in DONE; one more edge returns to IDLE.
        dp_o = 1'b0;
        @(posedge clk); #1;
        check("hit_cnt_hold", int'(hit_cnt), hits);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_drv",  int'(drv_i),   0);
        check("rst_busy", int'(busy),    0);
        check("rst_done", int'(done),    0);
        check("rst_hit",  int'(hit_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run(2, 3, 2, 1'b1, 1'b0);   // drv 0,0,0,1,1,0,0,0,1,1; hit 2
        run(1, 0, 0, 1'b0, 1'b0);   // zero lengths act as one cycle each
        run(0, 5, 5, 1'b0, 1'b0);   // immediate done, no busy
        run(15, 1, 1, 1'b1, 1'b0);  // hit_cnt reaches its maximum
        run(3, 2, 4, 1'b0, 1'b1);   // inputs changed mid-run are ignored

        // start held through a run and through DONE: exactly one run, then
        // a second one only after the IDLE cycle.
        dp_o = 1'b1;
        repeat (2) begin
            drv_exp_q.push_back(1'b0);
            drv_exp_q.push_back(1'b1);
            exp_q.push_back('{busy_len: 2, hits: 1});
        end
        start    = 1'b1;
        low_len  = CNT_W'(1);
        high_len = CNT_W'(1);
        reps     = REP_W'(1);
        @(posedge clk); #1;          // LOW
        low_len = CNT_W'(7);
        @(posedge clk); #1;          // HIGH
        @(posedge clk); #1;          // DONE (start still high)
        @(posedge clk); #1;          // IDLE
        low_len = CNT_W'(1);
        @(negedge clk);
        check("gap_idle_busy", int'(busy), 0);
        check("gap_idle_done", int'(done), 0);
        @(posedge clk); #1;          // second run LOW
        start = 1'b0;
        @(posedge clk); #1;          // HIGH
        @(posedge clk); #1;          // DONE
        @(posedge clk); #1;          // IDLE
        dp_o = 1'b0;

        // Reset in the middle of the first HIGH of an R=3 L=2 H=2 run
        dp_o = 1'b1;
        drv_exp_q.push_back(1'b0);
        drv_exp_q.push_back(1'b0);
        drv_exp_q.push_back(1'b1);
        start    = 1'b1;
        low_len  = CNT_W'(2);
        high_len = CNT_W'(2);
        reps     = REP_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;          // first HIGH cycle
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_drv",  int'(drv_i),   0);
        check("midrst_busy", int'(busy),    0);
        check("midrst_done", int'(done),    0);
        check("midrst_hit",  int'(hit_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dp_o  = 1'b0;
        @(posedge clk); #1;
        run(2, 2, 2, 1'b0, 1'b0);    // normal run after reset

`ifdef MINSEQ_ABORT_EN
        // Abort on the second repetition's HIGH cycle
        dp_o = 1'b1;
        drv_exp_q.push_back(1'b0);
        drv_exp_q.push_back(1'b1);
        drv_exp_q.push_back(1'b0);
        drv_exp_q.push_back(1'b1);
        start    = 1'b1;
        low_len  = CNT_W'(1);
        high_len = CNT_W'(1);
        reps     = REP_W'(4);
        @(posedge clk); #1;          // LOW rep 1
        start = 1'b0;
        @(posedge clk); #1;          // HIGH rep 1
        @(posedge clk); #1;          // LOW rep 2
        @(posedge clk); #1;          // HIGH rep 2
        abort = 1'b1;
        @(posedge clk); #1;          // back in IDLE
        abort = 1'b0;
        check("abort_busy", int'(busy),    0);
        check("abort_drv",  int'(drv_i),   0);
        check("abort_done", int'(done),    0);
        check("abort_hit",  int'(hit_cnt), 1);
        dp_o = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Randomized runs
        for (int n = 0; n < 30; n++) begin
            run(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), 1'b0, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("runs_left", exp_q.size(), 0);
        check("drv_left",  drv_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minimal_seq_ctrl.md
# minimal_seq_ctrl

Sequencer for the single-bit minimal datapath: drives its input line `i` through a programmable low/high waveform for a programmed number of repetitions. It samples the datapath output once per high phase and counts sampled highs. It sits between a test or control host (start/busy/done handshake) and one minimal datapath instance, replacing hand-written `#delay` stimulus with a clocked, repeatable schedule.

## Interface
Parameters:
- `CNT_W`, 8 — width of phase-length fields and phase counter.
- `REP_W`, 4 — width of repetition count and repetition counter.

Ports:
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — request a run; sampled only in IDLE.
- `low_len`  in  CNT_W  — cycles `drv_i` is held 0 per repetition; latched at start.
- `high_len`  in  CNT_W  — cycles `drv_i` is held 1 per repetition; latched at start.
- `reps`  in  REP_W  — number of low+high repetitions; latched at start.
- `dp_o`  in  1  — datapath output `o`, sampled on the last HIGH cycle.
- `drv_i`  out  1  — drives datapath input `i`.
- `busy`  out  1  — high in LOW and HIGH states.
- `done`  out  1  — one-cycle pulse at normal completion.
- `hit_cnt`  out  REP_W+1  — count of HIGH phases with `dp_o`=1 at sample point.
- `abort`  in  1  — present only with `MINSEQ_ABORT_EN`; see Configuration.

## Operation
- States: IDLE, LOW, HIGH, DONE. Registered Moore outputs.
- IDLE: `drv_i`=0, `busy`=0. On `start`=1, latch `low_len`, `high_len`, `reps`. Clear `hit_cnt`.
  - If `reps`=0, go to DONE.
  - Otherwise, go to LOW with phase counter = 0 and rep counter = 0.
- LOW: `drv_i`=0. After `max(low_len,1)` cycles, go to HIGH. A length of 0 is treated as 1.
- HIGH: `drv_i`=1. After `max(high_len,1)` cycles:
  - On the final HIGH cycle, sample `dp_o`. If 1, increment `hit_cnt`.
  - Increment the rep counter. If it equals latched `reps`, go to DONE; else go to LOW.
- DONE: exactly one cycle; `done`=1, `busy`=0, `drv_i`=0. Always returns to IDLE.
- `start` in LOW, HIGH or DONE is ignored; it is not queued.
- `hit_cnt` holds its value from the end of a run until the next accepted `start`.
- Input changes to `low_len`, `high_len` or `reps` mid-run have no effect.
- Counters never wrap within a run. `hit_cnt` maximum is 2^REP_W-1, which fits in REP_W+1 bits.

## Timing
- Reset values: state IDLE, `drv_i`=0, `busy`=0, `done`=0, `hit_cnt`=0, all internal counters 0.
- Reset assertion mid-run forces IDLE immediately, asynchronously, with the reset values above. No `done` pulse.
- Latency: `start` accepted at edge N → `busy`=1 and `drv_i`=0 from N+1.
- Run length with `reps`=R, `low_len`=L, `high_len`=H, each ≥1:
  - `busy` is high for R·(L+H) cycles.
  - `done` asserts on the cycle immediately after the last HIGH cycle.
- Run with `reps`=0: `done` pulses at N+1, `busy` stays 0, `drv_i` stays 0.
- The `dp_o` sample point is the last cycle with `drv_i`=1 in each repetition. Datapath combinational settle must fit within one cycle.
- Back-to-back runs: `start` asserted during DONE is ignored. Earliest accepted `start` is the cycle after DONE (IDLE).

## Configuration
- `MINSEQ_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 sampled in LOW or HIGH → IDLE next cycle, `drv_i`=0, `busy`=0, no `done` pulse.
  - `hit_cnt` keeps hits counted so far; a sample due in that same cycle is discarded.
  - `abort` has priority over any phase transition. `abort` in IDLE or DONE has no effect.
- Undefined: no `abort` port; runs always complete unless reset.

## Test plan
- Reset mid-HIGH of a R=3, L=2, H=2 run → outputs return to reset values immediately; no `done`; next `start` runs normally.
- R=2, L=3, H=2, `dp_o` tied 1 → `drv_i` sequence 0,0,0,1,1,0,0,0,1,1; `busy` high for 10 cycles; `done` on cycle 11; `hit_cnt`=2.
- R=1, L=0, H=0 → one LOW cycle, then one HIGH cycle, then `done`; `hit_cnt` equals the `dp_o` value at the HIGH cycle.
- R=0 → `done` pulse one cycle after `start`; `busy` and `drv_i` stay 0; `hit_cnt`=0.
- `start` held high through a R=1, L=1, H=1 run and through DONE → exactly one run; second run begins only after the IDLE cycle; `low_len` changed mid-run has no effect.
- (`MINSEQ_ABORT_EN`) R=4, L=1, H=1, `dp_o`=1, `abort` asserted on the 2nd repetition's HIGH cycle → IDLE next cycle; `hit_cnt`=1; no `done` pulse.
